// File: rtl/mbc5_rumble_ext.sv
// rtl/mbc5_rumble_ext.sv - MBC5 mapper with configurable bank widths, rumble motor stretch and bank-change strobe
module mbc5_rumble_ext #(
    parameter int ROM_BANK_W  = 9,
    parameter int RAM_BANK_W  = 4,
    parameter int RUMBLE      = 1,
    parameter int RUMBLE_HOLD = 4096
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    ce_cpu,
    input  logic                    savestate_load,
    input  logic [31:0]             savestate_data,
    inout  wire  [31:0]             savestate_back_b,
    input  logic                    has_ram,
    input  logic [RAM_BANK_W-1:0]   ram_mask,
    input  logic [ROM_BANK_W-1:0]   rom_mask,
    input  logic [14:0]             cart_addr,
    input  logic                    cart_a15,
    input  logic [7:0]              cart_mbc_type,
    input  logic                    cart_wr,
    input  logic [7:0]              cart_di,
    input  logic [7:0]              cram_di,
    inout  wire  [7:0]              cram_do_b,
    inout  wire  [RAM_BANK_W+12:0]  cram_addr_b,
    inout  wire  [ROM_BANK_W+13:0]  mbc_addr_b,
    inout  wire                     ram_enabled_b,
    inout  wire                     has_battery_b,
    inout  wire                     rumble_b,
    inout  wire                     bank_changed_b
);

    localparam int HOLD_W = (RUMBLE_HOLD > 0) ? $clog2(RUMBLE_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RUMBLE_HOLD);
    localparam logic [7:0] BIT3_CLR = 8'hF7;

    logic [ROM_BANK_W-1:0] rom_bank;
    logic [ROM_BANK_W-1:0] rom_bank_wr;
    logic [RAM_BANK_W-1:0] ram_bank;
    logic                  ram_en;
    logic                  motor;
    logic [HOLD_W-1:0]     hold_cnt;
    logic                  bank_changed;

    logic                  rumble_mode;
    logic                  cpu_wr;
    logic [ROM_BANK_W-1:0] rom_eff;
    logic [RAM_BANK_W-1:0] ram_eff;
    logic                  ram_enabled;
    logic [31:0]           ss_back;
    logic                  unused_ss;

    assign rumble_mode = (RUMBLE != 0) && (cart_mbc_type == 8'h1C ||
                         cart_mbc_type == 8'h1D || cart_mbc_type == 8'h1E);
    assign cpu_wr      = ce_cpu & cart_wr & ~cart_a15;
    assign unused_ss   = ^savestate_data;

    always_comb begin
        rom_bank_wr = rom_bank;
        if (cart_addr[14:12] == 3'b010)
            rom_bank_wr[7:0] = cart_di;
        else if (cart_addr[14:12] == 3'b011)
            rom_bank_wr[ROM_BANK_W-1:8] = cart_di[ROM_BANK_W-9:0];
    end

    always_ff @(posedge clk_sys) begin
        if (reset || !enable) begin
            rom_bank     <= ROM_BANK_W'(1);
            ram_bank     <= '0;
            ram_en       <= 1'b0;
            motor        <= 1'b0;
            hold_cnt     <= '0;
            bank_changed <= 1'b0;
        end else if (savestate_load) begin
            rom_bank     <= savestate_data[ROM_BANK_W-1:0];
            ram_bank     <= savestate_data[16 +: RAM_BANK_W];
            ram_en       <= savestate_data[24];
            motor        <= savestate_data[25];
            hold_cnt     <= '0;
            bank_changed <= 1'b0;
        end else begin
            bank_changed <= 1'b0;
            if (ce_cpu && hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
            if (cpu_wr) begin
                case (cart_addr[14:12])
                    3'b000, 3'b001: ram_en <= (cart_di == 8'h0A);
                    3'b010, 3'b011: begin
                        rom_bank     <= rom_bank_wr;
                        bank_changed <= (rom_bank_wr != rom_bank);
                    end
                    3'b100, 3'b101: begin
                        ram_bank <= cart_di[RAM_BANK_W-1:0];
                        if (rumble_mode) begin
                            motor <= cart_di[3];
                            // Motor-on cancels any stretch; only a 1->0 edge starts one
                            if (cart_di[3])
                                hold_cnt <= '0;
                            else if (motor)
                                hold_cnt <= HOLD_INIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rom_eff     = (cart_addr[14] ? rom_bank : '0) & rom_mask;
    // Bit 3 drives the motor in rumble carts, so it never reaches the RAM address
    assign ram_eff     = ram_bank & ram_mask &
                         (rumble_mode ? BIT3_CLR[RAM_BANK_W-1:0] : {RAM_BANK_W{1'b1}});
    assign ram_enabled = ram_en & has_ram;

    always_comb begin
        ss_back                     = '0;
        ss_back[ROM_BANK_W-1:0]     = rom_bank;
        ss_back[16 +: RAM_BANK_W]   = ram_bank;
        ss_back[24]                 = ram_en;
        ss_back[25]                 = motor;
    end

    assign savestate_back_b = enable ? ss_back : 'z;
    assign cram_do_b        = enable ? (ram_enabled ? cram_di : 8'hFF) : 'z;
    assign cram_addr_b      = enable ? {ram_eff, cart_addr[12:0]} : 'z;
    assign mbc_addr_b       = enable ? {rom_eff, cart_addr[13:0]} : 'z;
    assign ram_enabled_b    = enable ? ram_enabled : 1'bz;
    assign has_battery_b    = enable ? (cart_mbc_type == 8'h1B || cart_mbc_type == 8'h1E) : 1'bz;
    assign rumble_b         = enable ? (rumble_mode & (motor | (hold_cnt != '0))) : 1'bz;
    assign bank_changed_b   = enable ? bank_changed : 1'bz;

endmodule

// File: doc/mbc5_rumble_ext.md
# mbc5_rumble_ext

Parametrised MBC5-family cartridge mapper for the Game Boy core. It extends the standard MBC5 in three ways: configurable ROM/RAM bank widths, a rumble-cartridge mode with a stretched motor output, and a one-cycle bank-change strobe for the ROM prefetch/cache logic. It sits on the shared tri-state mapper bus alongside the other mappers and drives that bus only when `enable` is high. Savestate load and readback use a fixed 32-bit layout.

## Interface
Parameters:
- ROM_BANK_W, 9, ROM bank register width (9..16); ROM address = ROM_BANK_W+14 bits
- RAM_BANK_W, 4, RAM bank register width (1..8)
- RUMBLE, 1, 1 = rumble support compiled in; 0 = bank bit 3 is always a plain RAM address bit
- RUMBLE_HOLD, 4096, minimum motor-on stretch after a motor-off write, counted in ce_cpu ticks; 0 = no stretch

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  mapper selected; 0 tri-states every `_b` output and holds all registers at reset values
- ce_cpu  in  1  CPU clock enable
- savestate_load  in  1  load registers from savestate_data
- savestate_data  in  32  savestate image
- savestate_back_b  inout  32  current savestate image
- has_ram  in  1  cartridge has RAM
- ram_mask  in  RAM_BANK_W  RAM bank mirroring mask
- rom_mask  in  ROM_BANK_W  ROM bank mirroring mask
- cart_addr  in  15  CPU address [14:0]
- cart_a15  in  1  CPU address bit 15
- cart_mbc_type  in  8  cartridge header type byte
- cart_wr  in  1  CPU write
- cart_di  in  8  CPU write data
- cram_di  in  8  cart RAM read data
- cram_do_b  inout  8  RAM data to CPU
- cram_addr_b  inout  RAM_BANK_W+13  cart RAM address
- mbc_addr_b  inout  ROM_BANK_W+14  ROM byte address
- ram_enabled_b  inout  1  RAM access enabled
- has_battery_b  inout  1  battery-backed cart
- rumble_b  inout  1  motor drive
- bank_changed_b  inout  1  single-cycle ROM bank-change strobe

## Operation
- Register priority on each clk_sys edge, highest first: `reset`, then `~enable`, then `savestate_load`, then a CPU write qualified by `ce_cpu & cart_wr & ~cart_a15`.
- Reset values (both `reset` and `~enable`): rom_bank = 1, ram_bank = 0, ram_en = 0, motor = 0, hold_cnt = 0, bank_changed = 0.
- Writes are decoded on `cart_addr[14:12]`:
  - 000 or 001: ram_en set to (`cart_di` == 0x0A).
  - 010: rom_bank[7:0] set to `cart_di`.
  - 011: rom_bank[ROM_BANK_W-1:8] set to `cart_di[ROM_BANK_W-9:0]`.
  - 100 or 101: ram_bank set to `cart_di[RAM_BANK_W-1:0]`; in rumble mode, motor is also set to `cart_di[3]`.
  - 110 or 111: ignored.
- Rumble mode is `RUMBLE & (cart_mbc_type` is 0x1C, 0x1D or 0x1E`)`. In rumble mode, ram_bank bit 3 is forced to 0 in `cram_addr` but keeps its stored value.
- ROM address:
  - Effective bank is 0 when `cart_addr[14]` = 0, otherwise rom_bank.
  - Effective bank is ANDed with `rom_mask`.
  - `mbc_addr` = {masked bank, `cart_addr[13:0]`}.
  - Bank 0 is selectable at 0x4000; there is no 0 to 1 remap.
- `cram_addr` = {ram_bank & `ram_mask`, `cart_addr[12:0]`}.
- `ram_enabled` = ram_en & `has_ram`.
- `cram_do` = `ram_enabled` ? `cram_di` : 0xFF.
- `has_battery` = type 0x1B or 0x1E.
- Motor stretch:
  - On a write that takes motor from 1 to 0, hold_cnt loads RUMBLE_HOLD.
  - hold_cnt decrements on each `ce_cpu` while nonzero.
  - A write setting motor = 1 clears hold_cnt.
  - `rumble` = rumble mode & (motor | hold_cnt != 0).
- `bank_changed`: a registered pulse, high for exactly one clk_sys, issued when a qualified write to 010 or 011 changes the rom_bank value. Writing the same value produces no pulse. It is never asserted by reset or savestate load.
- Savestate layout:
  - [15:0] rom_bank, zero-extended.
  - [23:16] ram_bank, zero-extended.
  - [24] ram_en.
  - [25] motor.
  - [31:26] = 0.
  - Load also clears hold_cnt and bank_changed.

## Timing
- Register updates take effect on the clk_sys edge of the qualified write. `mbc_addr`, `cram_addr` and `rumble` reflect the new value in the next cycle; they are combinational from registers.
- `bank_changed` is asserted in the cycle after the write edge.
- A write with `ce_cpu` = 0 is ignored.
- hold_cnt does not wrap: at 0 it stays 0.
- Motor-off followed by motor-on within the hold window: `rumble` stays continuously high.
- `reset` during the hold window: `rumble` is 0 the next cycle.
- `savestate_load` and a write in the same cycle: the load wins and the write is lost.
- With RUMBLE_HOLD = 0, `rumble` follows motor directly.

## Test plan
- Reset, then read at 0x4123 -> `mbc_addr` = bank 1 (0x04123 with default widths); `rumble` = 0; `ram_enabled` = 0; `bank_changed` never high.
- ROM_BANK_W = 9: write 0x2000←0xFF, 0x3000←0x01, `rom_mask` = 0x1FF, read 0x7FFF -> `mbc_addr` = 0x7FFFFF. Rewrite 0x2000←0xFF -> no `bank_changed` pulse.
- Type 0x1C, RUMBLE_HOLD = 8: write 0x4000←0x0B then 0x4000←0x03 -> `cram_addr` bank = 3, `rumble` = 1. It stays 1 for exactly 8 `ce_cpu` ticks after the second write, then 0.
- Type 0x19 (no rumble): write 0x4000←0x0B with `ram_mask` = 0xF -> `cram_addr` bank = 0xB, `rumble` = 0.
- Write 0x0000←0x0A with `has_ram` = 1 -> `cram_do` = `cram_di`. Write 0x0000←0x00 -> `cram_do` = 0xFF.
- Savestate: load 0x0300_0105 -> `savestate_back_b` = 0x0300_0105, rom_bank = 0x105, motor = 1. Drop `enable` -> all `_b` outputs high-Z; re-enable -> `savestate_back_b` = 0x0000_0001.
